// File: rtl/riscv_pkg.sv
// Shared control definitions for the RISC-V multicycle and pipeline control paths.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; the functions have no storage.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
    } mc_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Per-state control word. Fields that need a live input (mem_ready, zero, op)
    // to become a strobe are carried as qualifiers and combined at the top level.
    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       branch;    // pcwrite follows the ALU zero flag
        logic       pcupdate;  // unconditional PC write
        logic       fetch;     // irwrite/pcwrite on mem_ready
        logic       done;      // unconditional retire
        logic       done_rdy;  // retire on mem_ready
        logic       decode;    // illegal-opcode check is live
        logic       mem_wait;  // state stalls on mem_ready
    } ctrl_t;

    function automatic logic op_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t state_ctrl(input mc_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.resultsrc = RES_ALURESULT;
                c.fetch     = 1'b1;
                c.mem_wait  = 1'b1;
            end
            DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
                c.decode  = 1'b1;
            end
            MEMADR: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
                c.mem_wait  = 1'b1;
            end
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
                c.done      = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
                c.memwrite  = 1'b1;
                c.done_rdy  = 1'b1;
                c.mem_wait  = 1'b1;
            end
            EXECUTER: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_RS2;
                c.aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
                c.done      = 1'b1;
            end
            BEQ: begin
                c.alusrca   = SRCA_RS1;
                c.alusrcb   = SRCB_RS2;
                c.aluop     = ALUOP_SUB;
                c.resultsrc = RES_ALUOUT;
                c.branch    = 1'b1;
                c.done      = 1'b1;
            end
            JAL: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALUOUT;
                c.pcupdate  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // op is only looked at in DECODE and MEMADR; every other state ignores it.
    function automatic mc_state_t next_state(input mc_state_t s,
                                             input logic [6:0] op,
                                             input logic       mem_ready);
        mc_state_t n;
        case (s)
            FETCH:    n = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXECUTER;
                    OP_I:         n = EXECUTEI;
                    OP_BEQ:       n = BEQ;
                    OP_JAL:       n = JAL;
                    default:      n = FETCH;
                endcase
            end
            MEMADR:   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  n = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    n = FETCH;
            MEMWRITE: n = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            ALUWB:    n = FETCH;
            BEQ:      n = FETCH;
            JAL:      n = ALUWB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format select from the opcode; shared by multicycle and pipeline decode.
// Latency: combinational.
// Backpressure: none.
module imm_src_dec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] immsrc
);

    // Opcode to immediate format; everything not S/B/J uses the I layout.
    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RISC-V datapath (shared memory, single ALU).
// Latency: one state per clock; lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles at full memory rate.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; long stalls raise sticky mem_timeout.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   STALL_MAX = CW'(TIMEOUT);

    mc_state_t     state;
    mc_state_t     state_nxt;
    ctrl_t         ctrl;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_nxt;
    logic          illegal;

    assign state_nxt = next_state(state, op, mem_ready);

    // State register plus the control word for the state being entered, so the
    // Moore selects come straight out of flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
        end
    end

    // The counter only runs while a wait state is stalled; any completion or
    // state change brings it back to zero. It saturates rather than wrapping.
    assign stall_nxt = (ctrl.mem_wait && !mem_ready)
                     ? ((stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + CW'(1))
                     : '0;

    // Stall counter and sticky timeout flag; the FSM keeps waiting regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (stall_nxt == STALL_MAX) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    imm_src_dec u_imm_src_dec (
        .op     (op),
        .immsrc (immsrc)
    );

    assign illegal = ctrl.decode && !op_legal(op);

    // Strobes are gated by reset so an abandoned instruction never writes state.
    assign pcwrite    = !reset && ((ctrl.branch && zero) || ctrl.pcupdate || (ctrl.fetch && mem_ready));
    assign irwrite    = !reset && ctrl.fetch && mem_ready;
    assign memwrite   = !reset && ctrl.memwrite;
    assign regwrite   = !reset && ctrl.regwrite;
    assign illegal_op = !reset && illegal;
    assign instr_done = !reset && (ctrl.done || (ctrl.done_rdy && mem_ready) || illegal);

    assign adrsrc    = ctrl.adrsrc;
    assign resultsrc = ctrl.resultsrc;
    assign alusrca   = ctrl.alusrca;
    assign alusrcb   = ctrl.alusrcb;
    assign aluop     = ctrl.aluop;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RISC-V datapath: one shared memory for instructions and data, plus a single ALU.
- Sequences every instruction through fetch, decode, execute, memory and writeback steps, one state per clock.
- Drives the mux selects and write strobes of the datapath, and stalls fetch and memory states on the memory handshake.
- Supports lw, sw, R-type, I-type ALU, beq and jal; all other opcodes are flagged illegal.

Parameters:
- TIMEOUT, 255, consecutive cycles of mem_ready=0 in a wait state before mem_timeout sets.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- op  in  7  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  PC write enable = (branch & zero) | pcupdate
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register / OldPC load
- regwrite  out  1  register file write
- resultsrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alusrca  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- alusrcb  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- aluop  out  2  00 = add, 01 = sub/compare, 10 = decode from funct
- immsrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- mem_timeout  out  1  sticky flag; cleared only by reset

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Reset: state = FETCH, stall counter = 0, mem_timeout = 0. While reset is high, pcwrite, irwrite, regwrite, memwrite, instr_done and illegal_op are forced to 0. Reset asserted mid-instruction abandons the instruction; no strobe fires.
- Outputs are Moore decodes of state, except immsrc (decoded from op) and pcwrite (uses zero). Any select not listed for a state is 00 or 0.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=pcupdate=mem_ready. If mem_ready, go to DECODE; else stay in FETCH.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (computes branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH, with illegal_op=1 and instr_done=1
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: resultsrc=01, regwrite=1, instr_done=1. Go to FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 held every cycle until mem_ready. On mem_ready: instr_done=1, go to FETCH.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10. Go to ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10. Go to ALUWB.
- ALUWB: resultsrc=00, regwrite=1, instr_done=1. Go to FETCH.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, so pcwrite=zero. instr_done=1. Go to FETCH.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1. Go to ALUWB, which writes PC+4 to rd.
- immsrc from op: sw -> 01, beq -> 10, jal -> 11, all others -> 00.
- Latency with mem_ready tied to 1, in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Stall counter:
  - increments while in FETCH, MEMREAD or MEMWRITE with mem_ready=0
  - clears on mem_ready=1 and on any state change
  - saturates at TIMEOUT
  - when it reaches TIMEOUT, mem_timeout sets
  - the FSM keeps waiting; the timeout does not abort the access
- op is sampled only in DECODE and MEMADR; changes to op in other states have no effect.

Decomposition:
- Shared package `riscv_pkg`:
  - state enum `mc_state_t`
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - select encodings: RES_*, SRCA_*, SRCB_*, ALUOP_*, IMM_*
- One combinational sub-module, `imm_src_dec` (op -> immsrc), shared with the pipeline decode stage.
- The FSM, output decode and stall counter stay in `multicycle_ctrl`.

Test Plan:
- mem_ready=1, op=0000011: state order FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite only in cycle 5 with resultsrc=01; instr_done in cycle 5.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE: memwrite held 4 cycles, instr_done on the 4th, immsrc=01 throughout.
- op=1100011 with zero=1, then zero=0: pcwrite=1 in BEQ for the first, 0 for the second; 3 cycles each; aluop=01.
- op=1101111: JAL state has pcwrite=1, alusrca=01, alusrcb=10; ALUWB then has regwrite=1; immsrc=11.
- op=1111111: illegal_op and instr_done pulse in DECODE; next state FETCH; no regwrite or memwrite.
- TIMEOUT=4, mem_ready=0 in FETCH: mem_timeout rises after 4 stall cycles and stays high. Asserting reset while in MEMREAD returns to FETCH and clears the flag; irwrite stays 0 while reset is high.
